// File: rtl/pulse_pacer_pkg.sv
// Shared types and constants for the pulse pacer: FSM state encoding and gap counter width.
package pulse_pacer_pkg;

   localparam int GAP_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } pacer_state_e;

endpackage : pulse_pacer_pkg

// File: rtl/sat_counter.sv
// Up/down saturating counter with synchronous clear; holds the pacer's queue depth.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         at_max
);

   assign at_max = (count == {W{1'b1}});

   // Simultaneous inc and dec cancel; clear takes priority over both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !dec && !at_max) begin
         count <= count + 1'b1;
      end else if (dec && !inc && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/pulse_pacer.sv
// Paces bursty events into single-cycle pulses separated by GAP_CYCLES idle cycles.
// Optional sticky overflow flag enabled by defining PULSE_PACER_OVF_EN.
module pulse_pacer
   import pulse_pacer_pkg::*;
#(
   parameter int GAP_CYCLES = 6,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             event_in,
   input  logic             flush,
   output logic             pulse_out,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output pacer_state_e     state_dbg
`ifdef PULSE_PACER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

   pacer_state_e         state_q;
   pacer_state_e         next_state;
   logic [GAP_CNT_W-1:0] gap_q;
   logic [GAP_CNT_W-1:0] gap_d;
   logic                 pending_nz;
   logic                 at_max;
   logic                 issue;
   logic                 drop;
   logic                 accept;

   assign pending_nz = (pending != '0);
   // A flush cancels an issue that would otherwise start on the same edge.
   assign issue      = (state_q == IDLE) && pending_nz && !flush;
   assign drop       = event_in && at_max && !issue && !flush;
   assign accept     = event_in && !drop;
   assign busy       = (state_q != IDLE) || pending_nz;
   assign state_dbg  = state_q;

   sat_counter #(
      .W(CNT_W)
   ) u_pending (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .inc   (accept),
      .dec   (issue),
      .count (pending),
      .at_max(at_max)
   );

   always_comb begin
      next_state = state_q;
      gap_d      = gap_q;
      case (state_q)
         IDLE: begin
            if (issue) next_state = PULSE;
         end
         PULSE: begin
            next_state = GAP;
            gap_d      = '0;
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               next_state = IDLE;
               gap_d      = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
            gap_d      = '0;
         end
      endcase
   end

   // pulse_out is registered from next_state so it tracks state == PULSE exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gap_q     <= '0;
         pulse_out <= 1'b0;
      end else begin
         state_q   <= next_state;
         gap_q     <= gap_d;
         pulse_out <= (next_state == PULSE);
      end
   end

`ifdef PULSE_PACER_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (flush) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule : pulse_pacer

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer: table of per-cycle vectors plus multi-cycle corner sequences.
module tb_pulse_pacer;
   import pulse_pacer_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ev_a = 1'b0, fl_a = 1'b0, ev_b = 1'b0, fl_b = 1'b0;
   logic         pulse_a, pulse_b, busy_a, busy_b;
   logic [3:0]   pend_a;
   logic [1:0]   pend_b;
   pacer_state_e st_a, st_b;
`ifdef PULSE_PACER_OVF_EN
   logic         ovf_a, ovf_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pulse_pacer #(.GAP_CYCLES(6), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .event_in(ev_a), .flush(fl_a),
      .pulse_out(pulse_a), .pending(pend_a), .busy(busy_a), .state_dbg(st_a)
`ifdef PULSE_PACER_OVF_EN
      , .ovf(ovf_a)
`endif
   );

   pulse_pacer #(.GAP_CYCLES(6), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .event_in(ev_b), .flush(fl_b),
      .pulse_out(pulse_b), .pending(pend_b), .busy(busy_b), .state_dbg(st_b)
`ifdef PULSE_PACER_OVF_EN
      , .ovf(ovf_b)
`endif
   );

   typedef struct {
      logic ev;
      logic fl;
      logic pulse;
      int   pend;
      logic busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic ev, input logic fl, input logic p,
                               input int pend, input logic b);
      vec_t v;
      v.ev = ev; v.fl = fl; v.pulse = p; v.pend = pend; v.busy = b;
      vecs.push_back(v);
   endfunction

   function automatic void add_gap(input int n, input int pend);
      for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, pend, 1'b1);
   endfunction

   task automatic drain_a(input string name, output int np);
      int n;
      n  = 0;
      np = 0;
      while (busy_a && n < 200) begin
         tick();
         n++;
         if (pulse_a) np++;
      end
      check({name, "_idle"}, int'(busy_a), 0);
   endtask

   task automatic drain_b(input string name, inout int np);
      int n;
      n = 0;
      while (busy_b && n < 200) begin
         tick();
         n++;
         if (pulse_b) np++;
      end
      check({name, "_idle"}, int'(busy_b), 0);
   endtask

   initial begin
      int np;

      // Single event: one pulse, then six gap cycles, then idle.
      add(1, 0, 0, 1, 1);
      add(0, 0, 1, 0, 1);
      add_gap(6, 0);
      add(0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0);
      // Burst of three: pulses eight cycles apart, queue peaks at two.
      add(1, 0, 0, 1, 1);
      add(1, 0, 1, 1, 1);
      add(1, 0, 0, 2, 1);
      add_gap(5, 2);
      add(0, 0, 0, 2, 1);
      add(0, 0, 1, 1, 1);
      add_gap(6, 1);
      add(0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 1);
      add_gap(6, 0);
      add(0, 0, 0, 0, 0);
      // Flush coincident with event: event dropped.
      add(1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0);

      // Reset state
      tick();
      check("rst_pulse", int'(pulse_a), 0);
      check("rst_pending", int'(pend_a), 0);
      check("rst_busy", int'(busy_a), 0);
      check("rst_state", int'(st_a), int'(IDLE));
`ifdef PULSE_PACER_OVF_EN
      check("rst_ovf", int'(ovf_a), 0);
`endif
      rst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         ev_a = vecs[i].ev;
         fl_a = vecs[i].fl;
         tick();
         check($sformatf("vec%0d_pulse", i), int'(pulse_a), int'(vecs[i].pulse));
         check($sformatf("vec%0d_pending", i), int'(pend_a), vecs[i].pend);
         check($sformatf("vec%0d_busy", i), int'(busy_a), int'(vecs[i].busy));
      end
      ev_a = 1'b0;
      fl_a = 1'b0;

      // Simultaneous issue and event with two queued.
      ev_a = 1'b1;
      repeat (3) tick();
      ev_a = 1'b0;
      repeat (6) tick();
      check("simul_pre_pending", int'(pend_a), 2);
      check("simul_pre_pulse", int'(pulse_a), 0);
      ev_a = 1'b1;
      tick();
      ev_a = 1'b0;
      check("simul_pulse", int'(pulse_a), 1);
      check("simul_pending", int'(pend_a), 2);
      drain_a("simul", np);
      check("simul_pulses", np, 2);

      // Saturation on the two-bit instance.
      np = 0;
      ev_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (pulse_b) np++;
      end
      check("sat_pending4", int'(pend_b), 3);
`ifdef PULSE_PACER_OVF_EN
      check("sat_ovf4", int'(ovf_b), 0);
`endif
      tick();
      if (pulse_b) np++;
      ev_b = 1'b0;
      check("sat_pending5", int'(pend_b), 3);
`ifdef PULSE_PACER_OVF_EN
      check("sat_ovf5", int'(ovf_b), 1);
`endif
      drain_b("sat", np);
      check("sat_pulses", np, 4);
`ifdef PULSE_PACER_OVF_EN
      check("sat_ovf_sticky", int'(ovf_b), 1);
      fl_b = 1'b1;
      tick();
      fl_b = 1'b0;
      check("sat_ovf_flushed", int'(ovf_b), 0);
`endif

      // Flush during GAP with five queued.
      ev_a = 1'b1;
      repeat (6) tick();
      ev_a = 1'b0;
      check("flush_pre_pending", int'(pend_a), 5);
      check("flush_pre_state", int'(st_a), int'(GAP));
      fl_a = 1'b1;
      tick();
      fl_a = 1'b0;
      check("flush_pending", int'(pend_a), 0);
      check("flush_busy0", int'(busy_a), 1);
      tick();
      check("flush_busy1", int'(busy_a), 1);
      tick();
      check("flush_busy2", int'(busy_a), 0);
      np = 0;
      repeat (10) begin
         tick();
         if (pulse_a) np++;
      end
      check("flush_no_pulse", np, 0);

      // Asynchronous reset during PULSE.
      ev_a = 1'b1;
      repeat (2) tick();
      ev_a = 1'b0;
      check("rstp_pre_pulse", int'(pulse_a), 1);
      check("rstp_pre_pending", int'(pend_a), 1);
      #2 rst = 1'b1;
      #1;
      check("rstp_pulse", int'(pulse_a), 0);
      check("rstp_pending", int'(pend_a), 0);
      check("rstp_busy", int'(busy_a), 0);
      tick();
      rst = 1'b0;
      tick();

      // Asynchronous reset during GAP, then latency after release.
      ev_a = 1'b1;
      repeat (3) tick();
      ev_a = 1'b0;
      check("rstg_pre_state", int'(st_a), int'(GAP));
      check("rstg_pre_pending", int'(pend_a), 2);
      #2 rst = 1'b1;
      #1;
      check("rstg_pulse", int'(pulse_a), 0);
      check("rstg_pending", int'(pend_a), 0);
      check("rstg_busy", int'(busy_a), 0);
      check("rstg_state", int'(st_a), int'(IDLE));
      #2 rst = 1'b0;
      ev_a = 1'b1;
      tick();
      ev_a = 1'b0;
      check("post_rst_pending", int'(pend_a), 1);
      check("post_rst_pulse0", int'(pulse_a), 0);
      tick();
      check("post_rst_pulse1", int'(pulse_a), 1);
      check("post_rst_pending1", int'(pend_a), 0);
      tick();
      check("post_rst_pulse2", int'(pulse_a), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pulse_pacer
